// File: rtl/anneal_seq_pkg.sv
// Shared types and default sizes for the anneal sequencer.
package anneal_seq_pkg;

  localparam int unsigned NumSpinDefault         = 256;
  localparam int unsigned CounterBitwidthDefault = 16;

  typedef enum logic [3:0] {
    StIdle,
    StCfg,
    StDtStart,
    StDtGuard,
    StDtWait,
    StPush,
    StCollect,
    StCheck,
    StDone
  } anneal_state_e;

endpackage

// File: rtl/anneal_sequencer_if.sv
// Wrapper-facing handshakes of the anneal sequencer: configure pulse, J/h launch/idle,
// spin push (valid/ready) and spin result (valid/ready).
interface anneal_sequencer_if
  import anneal_seq_pkg::*;
#(
  parameter int unsigned NumSpin = NumSpinDefault
) ();

  logic               wrap_cfg_en_o;
  logic               dt_cfg_enable_o;
  logic               dt_cfg_idle_i;
  logic               spin_pop_valid_o;
  logic               spin_pop_ready_i;
  logic [NumSpin-1:0] spin_pop_o;
  logic               spin_valid_i;
  logic               spin_ready_o;
  logic [NumSpin-1:0] spin_i;

  modport master (
    output wrap_cfg_en_o, dt_cfg_enable_o, spin_pop_valid_o, spin_pop_o, spin_ready_o,
    input  dt_cfg_idle_i, spin_pop_ready_i, spin_valid_i, spin_i
  );

  modport slave (
    input  wrap_cfg_en_o, dt_cfg_enable_o, spin_pop_valid_o, spin_pop_o, spin_ready_o,
    output dt_cfg_idle_i, spin_pop_ready_i, spin_valid_i, spin_i
  );

endinterface

// File: rtl/anneal_stability_tracker.sv
// Holds the current spin vector and counts consecutive unchanged iterations.
// Optional feature macro: ANNEAL_SEQ_FLIP_COUNT_EN adds flip_cnt_o (Hamming distance of the
// latest captured spin vector against the previous one).
module anneal_stability_tracker
  import anneal_seq_pkg::*;
#(
  parameter int unsigned NumSpin         = NumSpinDefault,
  parameter int unsigned CounterBitwidth = CounterBitwidthDefault
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_i,
  input  logic [NumSpin-1:0]         init_spin_i,
  input  logic                       capture_i,
  input  logic [NumSpin-1:0]         spin_i,
  output logic [NumSpin-1:0]         spin_o,
  output logic [CounterBitwidth-1:0] stable_cnt_o
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
  ,
  output logic [$clog2(NumSpin):0]   flip_cnt_o
`endif
);

  logic [NumSpin-1:0]         spin_q;
  logic [CounterBitwidth-1:0] stable_q;
  logic                       unchanged;

  assign unchanged    = (spin_i == spin_q);
  assign spin_o       = spin_q;
  assign stable_cnt_o = stable_q;

  // Load the initial vector on start; on each capture update the vector and stability run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spin_q   <= '0;
      stable_q <= '0;
    end else if (load_i) begin
      spin_q   <= init_spin_i;
      stable_q <= '0;
    end else if (capture_i) begin
      spin_q <= spin_i;
      if (!unchanged) begin
        stable_q <= '0;
      end else if (stable_q != '1) begin
        stable_q <= stable_q + 1'b1;
      end
    end
  end

`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
  localparam int unsigned FlipW = $clog2(NumSpin) + 1;
  logic [FlipW-1:0] flip_q;

  assign flip_cnt_o = flip_q;

  // Hamming distance of the newly captured vector against the one it replaces.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flip_q <= '0;
    end else if (capture_i) begin
      flip_q <= FlipW'($countones(spin_i ^ spin_q));
    end
  end
`endif

endmodule

// File: rtl/anneal_sequencer.sv
// Anneal sequencer: configure pulse, J/h launch and idle wait, then the push/collect/check
// iteration loop with iteration-count and stability-based termination.
// Optional feature macro: ANNEAL_SEQ_FLIP_COUNT_EN (adds flip_cnt_o).
module anneal_sequencer
  import anneal_seq_pkg::*;
#(
  parameter int unsigned NumSpin         = NumSpinDefault,
  parameter int unsigned CounterBitwidth = CounterBitwidthDefault
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [CounterBitwidth-1:0] iter_max_i,
  input  logic [CounterBitwidth-1:0] stable_thresh_i,
  input  logic [NumSpin-1:0]         init_spin_i,
  anneal_sequencer_if.master         wrap,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       converged_o,
  output logic [CounterBitwidth-1:0] iter_cnt_o,
  output logic [NumSpin-1:0]         final_spin_o
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
  ,
  output logic [$clog2(NumSpin):0]   flip_cnt_o
`endif
);

  anneal_state_e              state_q, state_d;
  logic [CounterBitwidth-1:0] iter_max_q, thresh_q, iter_cnt_q, stable_cnt;
  logic                       converged_q;
  logic [NumSpin-1:0]         spin_reg;
  logic                       load, capture, set_conv;
  logic                       stable_hit;

  assign stable_hit = (thresh_q != '0) && (stable_cnt >= thresh_q);

  // Next-state decode; abort overrides every transition and suppresses all side effects.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    capture  = 1'b0;
    set_conv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = StCfg;
        end
      end
      StCfg:     state_d = StDtStart;
      StDtStart: state_d = StDtGuard;
      // Idle may still be stale from before the launch, so it is ignored for one cycle.
      StDtGuard: state_d = StDtWait;
      StDtWait: begin
        if (wrap.dt_cfg_idle_i) state_d = (iter_max_q == '0) ? StDone : StPush;
      end
      StPush: begin
        if (wrap.spin_pop_ready_i) state_d = StCollect;
      end
      StCollect: begin
        if (wrap.spin_valid_i) begin
          capture = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (stable_hit) begin
          set_conv = 1'b1;
          state_d  = StDone;
        end else if (iter_cnt_q == iter_max_q) begin
          state_d = StDone;
        end else begin
          state_d = StPush;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d  = StIdle;
      load     = 1'b0;
      capture  = 1'b0;
      set_conv = 1'b0;
    end
  end

  // State and run bookkeeping; everything freezes while en_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      iter_max_q  <= '0;
      thresh_q    <= '0;
      iter_cnt_q  <= '0;
      converged_q <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      if (load) begin
        iter_max_q  <= iter_max_i;
        thresh_q    <= stable_thresh_i;
        iter_cnt_q  <= '0;
        converged_q <= 1'b0;
      end else begin
        if (capture)  iter_cnt_q  <= iter_cnt_q + 1'b1;
        if (set_conv) converged_q <= 1'b1;
      end
    end
  end

  anneal_stability_tracker #(
    .NumSpin         (NumSpin),
    .CounterBitwidth (CounterBitwidth)
  ) u_tracker (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (load & en_i),
    .init_spin_i  (init_spin_i),
    .capture_i    (capture & en_i),
    .spin_i       (wrap.spin_i),
    .spin_o       (spin_reg),
    .stable_cnt_o (stable_cnt)
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
    ,
    .flip_cnt_o   (flip_cnt_o)
`endif
  );

  // Outputs are pure state decodes, so they hold (pulses included) while en_i is low.
  assign wrap.wrap_cfg_en_o    = (state_q == StCfg);
  assign wrap.dt_cfg_enable_o  = (state_q == StDtStart);
  assign wrap.spin_pop_valid_o = (state_q == StPush);
  assign wrap.spin_pop_o       = (state_q == StPush) ? spin_reg : '0;
  assign wrap.spin_ready_o     = (state_q == StCollect);
  assign busy_o                = (state_q != StIdle);
  assign done_o                = (state_q == StDone);
  assign converged_o           = converged_q;
  assign iter_cnt_o            = iter_cnt_q;
  assign final_spin_o          = spin_reg;

endmodule

// File: tb/tb_anneal_sequencer.sv
// Self-checking bench for anneal_sequencer: directed table of runs plus randomized runs,
// all checked against a loop-level reference model of the anneal procedure.
module tb_anneal_sequencer;
  import anneal_seq_pkg::*;

  localparam int unsigned NS = NumSpinDefault;
  localparam int unsigned CW = CounterBitwidthDefault;

  typedef logic [NS-1:0] spin_t;

  typedef struct {
    spin_t       init;
    logic [15:0] iter_max;
    logic [15:0] thresh;
    int          mode;       // 0: flip bit 0, 1: constant vector, 2: random/echo table
    bit          stale;      // dt idle stuck high
    bit          stall;      // ready held low 5 cycles on first push
    bit          abort_col;  // abort in first COLLECT
    bit          en_low;     // en low 3 cycles in CFG
    int          exp_iters;
    bit          exp_conv;
    int          exp_done;
    int          exp_push;
  } case_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic en = 1'b1, start = 1'b0, abort = 1'b0;
  logic [CW-1:0] iter_max = '0, stable_thresh = '0;
  spin_t init_spin = '0;
  logic busy, done, converged;
  logic [CW-1:0] iter_cnt;
  spin_t final_spin;
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
  logic [$clog2(NS):0] flip_cnt;
`endif

  int total = 0;
  int bad = 0;

  spin_t const_v;
  spin_t rnd_tab[16];
  bit    echo_tab[16];
  int    cur_mode;

  anneal_sequencer_if #(.NumSpin(NS)) wif ();

  anneal_sequencer #(.NumSpin(NS), .CounterBitwidth(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .en_i            (en),
    .start_i         (start),
    .abort_i         (abort),
    .iter_max_i      (iter_max),
    .stable_thresh_i (stable_thresh),
    .init_spin_i     (init_spin),
    .wrap            (wif.master),
    .busy_o          (busy),
    .done_o          (done),
    .converged_o     (converged),
    .iter_cnt_o      (iter_cnt),
    .final_spin_o    (final_spin)
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
    ,
    .flip_cnt_o      (flip_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic spin_t rand_spin();
    spin_t v;
    for (int i = 0; i < NS / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // What the analog macro returns for iteration k given the vector it was pushed.
  function automatic spin_t resp(input spin_t prev, input int k);
    spin_t one = 1;
    case (cur_mode)
      0:       return prev ^ one;
      1:       return const_v;
      default: return echo_tab[k % 16] ? prev : rnd_tab[k % 16];
    endcase
  endfunction

  // Reference: the annealing loop written as a plain for-loop over iterations.
  task automatic model(input case_t c, output spin_t seq[$], output int iters, output bit conv,
                       output spin_t fin, output int flips);
    spin_t s, r;
    int stable;
    s = c.init; stable = 0; iters = 0; conv = 0; flips = 0;
    seq.delete();
    for (int k = 1; k <= int'(c.iter_max); k++) begin
      seq.push_back(s);
      r = resp(s, k);
      flips = $countones(r ^ s);
      stable = (r == s) ? stable + 1 : 0;
      s = r;
      iters = k;
      if (c.thresh != 0 && stable >= int'(c.thresh)) begin
        conv = 1;
        break;
      end
    end
    fin = s;
  endtask

  task automatic run_case(input case_t c);
    spin_t seq[$];
    spin_t m_fin, held, prev_push;
    int m_iters, m_flips;
    bit m_conv;
    int ncfg = 0, ndt = 0, ndone = 0, npush = 0;
    int hold = 0, stall = 0, vdel = 0, idle_del, dt_cyc = -1, last_hs = -1;
    bit en_used = 0, in_push = 0, in_col = 0, fin = 0, aborting = 0, seen_push = 0;

    cur_mode = c.mode;
    model(c, seq, m_iters, m_conv, m_fin, m_flips);
    idle_del = $urandom_range(0, 4);
    prev_push = c.init;

    iter_max = c.iter_max; stable_thresh = c.thresh; init_spin = c.init; start = 1'b1;
    step();
    start = 1'b0;
    // Later changes must not matter: values were latched at start.
    iter_max = CW'($urandom); stable_thresh = CW'($urandom); init_spin = rand_spin();

    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (c.en_low && !en_used && wif.wrap_cfg_en_o) begin
        en_used = 1; hold = 3;
      end
      en = (hold == 0);
      if (hold > 0) begin
        chk("cfg_held_en_low", NS'(wif.wrap_cfg_en_o), NS'(1));
        hold--;
      end
      if (en && wif.wrap_cfg_en_o) ncfg++;
      if (en && wif.dt_cfg_enable_o) begin ndt++; dt_cyc = cyc; end
      wif.dt_cfg_idle_i = c.stale || (dt_cyc < 0) || (cyc >= dt_cyc + 2 + idle_del);

      wif.spin_pop_ready_i = 1'b0;
      if (wif.spin_pop_valid_o) begin
        if (!in_push) begin
          in_push = 1; held = wif.spin_pop_o;
          stall = (c.stall && npush == 0) ? 5 : $urandom_range(0, 2);
          if (!seen_push) begin
            seen_push = 1;
            chk("guard_gap", NS'(cyc - dt_cyc >= 3), NS'(1));
          end
        end else begin
          chk("pop_stable", wif.spin_pop_o, held);
        end
        wif.spin_pop_ready_i = (stall == 0);
        if (stall > 0) stall--;
        if (wif.spin_pop_ready_i && en) begin
          if (npush < seq.size()) chk("pop_value", wif.spin_pop_o, seq[npush]);
          else chk("pop_extra", NS'(npush), NS'(seq.size()));
          if (last_hs >= 0) chk("push_gap", NS'(cyc - last_hs >= 3), NS'(1));
          last_hs = cyc; prev_push = wif.spin_pop_o; npush++; in_push = 0;
        end
      end

      wif.spin_valid_i = 1'b0;
      wif.spin_i = rand_spin();
      if (wif.spin_ready_o) begin
        wif.spin_i = resp(prev_push, npush);
        if (c.abort_col) begin
          abort = 1'b1; wif.spin_valid_i = 1'b1; aborting = 1;
        end else begin
          if (!in_col) begin in_col = 1; vdel = $urandom_range(0, 2); end
          wif.spin_valid_i = (vdel == 0);
          if (vdel > 0) vdel--;
          if (wif.spin_valid_i && en) in_col = 0;
        end
      end

      if (en && done) begin ndone++; fin = 1; end
      step();
      if (aborting) begin
        abort = 1'b0; fin = 1;
        chk("abort_busy", NS'(busy), NS'(0));
        chk("abort_no_done", NS'(done), NS'(0));
      end
    end
    en = 1'b1;
    wif.spin_valid_i = 1'b0;
    wif.spin_pop_ready_i = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout: got no done want done");
    end else if (!aborting) begin
      chk("done_one_cycle", NS'(done), NS'(0));
      chk("idle_after_done", NS'(busy), NS'(0));
    end
    chk("cfg_pulses", NS'(ncfg), NS'(1));
    chk("dt_pulses", NS'(ndt), NS'(1));
    chk("done_pulses", NS'(ndone), NS'(c.exp_done));
    chk("push_count", NS'(npush), NS'(c.exp_push));
    chk("iter_cnt", NS'(iter_cnt), NS'(c.exp_iters));
    chk("converged", NS'(converged), NS'(c.exp_conv));
    chk("final_spin", final_spin, c.abort_col ? c.init : m_fin);
`ifdef ANNEAL_SEQ_FLIP_COUNT_EN
    if (!c.abort_col && m_iters > 0) chk("flip_cnt", NS'(flip_cnt), NS'(m_flips));
`endif
  endtask

  case_t tab[8];
  spin_t ini;

  initial begin
    case_t rc;
    spin_t seq_d[$];
    spin_t fin_d;
    int it_d, fl_d;
    bit cv_d;

    const_v = {8{32'hA5A5_0F0F}};
    ini     = {8{32'h1234_5678}};
    //             init iter  thr mode stale stall abort enlow iters conv done push
    tab[0] = '{ini, 16'd4,   16'd0, 0, 0, 0, 0, 0, 4, 0, 1, 4};
    tab[1] = '{ini, 16'd100, 16'd2, 1, 0, 0, 0, 0, 3, 1, 1, 3};
    tab[2] = '{ini, 16'd0,   16'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tab[3] = '{ini, 16'd2,   16'd0, 0, 1, 0, 0, 0, 2, 0, 1, 2};
    tab[4] = '{ini, 16'd3,   16'd0, 0, 0, 1, 1, 0, 0, 0, 0, 1};
    tab[5] = '{ini, 16'd2,   16'd0, 0, 0, 0, 0, 1, 2, 0, 1, 2};
    tab[6] = '{ini, 16'd5,   16'd1, 0, 0, 0, 0, 0, 5, 0, 1, 5};
    tab[7] = '{ini, 16'd3,   16'd3, 1, 0, 0, 0, 0, 3, 0, 1, 3};

    wif.dt_cfg_idle_i = 1'b1; wif.spin_pop_ready_i = 1'b0;
    wif.spin_valid_i = 1'b0; wif.spin_i = '0;

    #2;
    chk("rst_busy", NS'(busy), NS'(0));
    chk("rst_done", NS'(done), NS'(0));
    chk("rst_iter_cnt", NS'(iter_cnt), NS'(0));
    chk("rst_final_spin", final_spin, '0);
    chk("rst_cfg_en", NS'(wif.wrap_cfg_en_o), NS'(0));
    chk("rst_pop", wif.spin_pop_o, '0);
    chk("rst_converged", NS'(converged), NS'(0));
    step(); step();
    rst_ni = 1'b1;
    step();

    // start and abort together in IDLE: abort wins
    iter_max = 16'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", NS'(busy), NS'(0));

    for (int i = 0; i < 8; i++) begin
      run_case(tab[i]);
      step();
    end

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 16; k++) begin
        rnd_tab[k] = rand_spin();
        echo_tab[k] = ($urandom_range(0, 1) == 1);
      end
      rc.init = rand_spin();
      rc.iter_max = 16'($urandom_range(0, 8));
      rc.thresh = 16'($urandom_range(0, 3));
      rc.mode = 2;
      rc.stale = ($urandom_range(0, 1) == 1);
      rc.stall = 0; rc.abort_col = 0; rc.en_low = 0;
      cur_mode = 2;
      model(rc, seq_d, it_d, cv_d, fin_d, fl_d);
      rc.exp_iters = it_d; rc.exp_conv = cv_d; rc.exp_done = 1; rc.exp_push = it_d;
      run_case(rc);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anneal_sequencer.md
Name: anneal_sequencer

Overview:
- Top-level controller for the analog Ising macro wrapper.
- On a start pulse it runs three phases in order:
  - Pulses the wrapper's configure enable.
  - Launches J/h data configuration and waits until that configuration is idle.
  - Runs an iteration loop: push a spin vector into the wrapper, collect the resulting spin vector, feed it back.
- The loop stops after a programmed iteration count, or earlier once the spin state has been unchanged for a programmed number of consecutive iterations.
- Sits between the CSR/host front end and the wrapper; it drives the wrapper's configure, spin-pop and spin-output handshakes.

Parameters:
- num_spin, 256, spin vector width.
- counter_bitwidth, 16, width of iteration and stability counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  global enable; when low, the FSM and all registers hold.
- start_i  in  1  start pulse; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE from any state.
- iter_max_i  in  counter_bitwidth  maximum iterations; latched at start.
- stable_thresh_i  in  counter_bitwidth  consecutive-unchanged count for early stop; 0 disables early stop; latched at start.
- init_spin_i  in  num_spin  initial spin vector; latched at start.
- wrap_cfg_en_o  out  1  one-cycle configure pulse to the wrapper.
- dt_cfg_enable_o  out  1  one-cycle J/h configuration launch.
- dt_cfg_idle_i  in  1  J/h configuration idle status.
- spin_pop_valid_o  out  1  spin push valid.
- spin_pop_ready_i  in  1  spin push ready.
- spin_pop_o  out  num_spin  spin vector pushed.
- spin_valid_i  in  1  result spin valid.
- spin_ready_o  out  1  result spin ready.
- spin_i  in  num_spin  result spin vector.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- converged_o  out  1  run ended by the stability criterion; held until next start.
- iter_cnt_o  out  counter_bitwidth  completed iterations.
- final_spin_o  out  num_spin  current/last spin state.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal spin register 0.
- FSM states: IDLE, CFG, DT_START, DT_GUARD, DT_WAIT, PUSH, COLLECT, CHECK, DONE.
- IDLE:
  - start_i=1 latches iter_max_i, stable_thresh_i and init_spin_i.
  - Clears iter_cnt, stable_cnt and converged_o.
  - Next state CFG.
- CFG: wrap_cfg_en_o=1 for exactly one cycle; next DT_START.
- DT_START: dt_cfg_enable_o=1 for one cycle; next DT_GUARD.
- DT_GUARD: one cycle; dt_cfg_idle_i is ignored here; next DT_WAIT.
- DT_WAIT:
  - Waits for dt_cfg_idle_i=1.
  - Then, if latched iter_max=0, go to DONE; otherwise go to PUSH.
- PUSH:
  - spin_pop_valid_o=1 and spin_pop_o = spin register.
  - Both stay stable until spin_pop_ready_i=1; on that handshake, next COLLECT.
  - spin_pop_o is 0 outside PUSH.
- COLLECT:
  - spin_ready_o=1; on spin_valid_i=1, capture spin_i.
  - If spin_i equals the spin register, stable_cnt += 1 (saturating); otherwise stable_cnt = 0.
  - Spin register <= spin_i; iter_cnt += 1.
  - Next CHECK.
- CHECK:
  - If stable_thresh != 0 and stable_cnt >= stable_thresh: converged_o=1, next DONE.
  - Else if iter_cnt == iter_max: next DONE.
  - Else: next PUSH.
- DONE: done_o=1 for one cycle; next IDLE.
- Latency: the minimum from one push handshake to the next is 3 cycles (PUSH to COLLECT to CHECK to PUSH).
- final_spin_o: continuously equals the spin register; holds after DONE.
- iter_cnt_o: holds after DONE.
- Counter width: iter_cnt never exceeds iter_max, so it cannot wrap.
- abort_i:
  - Has priority over every transition, including in PUSH with valid high.
  - Next state IDLE, with no done_o pulse.
  - Counters and spin register keep their values.
- en_i low: state, counters and outputs hold, including pulse outputs; a held pulse completes when en_i returns.
- start_i outside IDLE is ignored.
- Simultaneous start_i and abort_i in IDLE: abort wins; stay in IDLE.

Optional Feature:
- Macro: ANNEAL_SEQ_FLIP_COUNT_EN.
- When defined:
  - Adds output flip_cnt_o, width $clog2(num_spin)+1.
  - Updated in COLLECT to popcount(spin_i XOR spin register), i.e. the Hamming distance of the latest iteration.
  - Resets to 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Package anneal_seq_pkg holds the FSM state enum typedef anneal_state_e and the default parameter constants.
- One sub-module, anneal_stability_tracker, owns the compare, stable_cnt and spin register, plus the optional popcount.

Test Plan:
- iter_max=4, stable_thresh=0, macro returns init XOR 1 each time: expect exactly 4 push handshakes, iter_cnt_o=4, converged_o=0, one done_o pulse.
- iter_max=100, stable_thresh=2, macro returns a constant vector V (not equal to init): expect iterations 1/2/3 to give stable_cnt 0/1/2; converged_o=1; iter_cnt_o=3; final_spin_o=V.
- iter_max=0: expect a wrap_cfg_en_o pulse, a dt_cfg_enable_o pulse, a wait for idle, then done_o with no spin_pop_valid_o.
- dt_cfg_idle_i held high throughout (stale idle): expect DT_GUARD to prevent skipping, and the first push no earlier than 3 cycles after the dt_cfg_enable_o pulse.
- spin_pop_ready_i low for 5 cycles: expect spin_pop_valid_o and spin_pop_o stable for all 5 cycles; then abort_i in COLLECT gives busy_o=0 next cycle and no done_o.
- en_i low for 3 cycles during CFG: expect wrap_cfg_en_o held high, with the FSM resuming correctly afterwards.
